serial_subtractor: RTL and testbench

- Bit-serial multi-bit subtractor: computes a − b − bin over WIDTH bits, LSB first, one bit per clock.
- Built around one 1-bit full-subtractor cell, with a registered borrow fed back into that cell.
- Sits directly downstream of the combinational full-subtractor cell and consumes its diff/borrow outputs every cycle.
- Used where area matters more than latency; start/done handshake toward the issuing controller.

---
 rtl/serial_sub_pkg.sv | 17 +
 rtl/full_subractor.sv | 13 +
 rtl/serial_subtractor.sv | 129 ++++++++++++
 tb/tb_serial_subtractor.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and elaboration limits for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 64;

    function automatic bit width_ok(input int unsigned w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/full_subractor.sv
// 1-bit full subtractor: diff = a - b - c, borrow set when the result underflows.
module full_subractor (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic diff,
    output logic borrow
);

    assign diff   = a ^ b ^ c;
    assign borrow = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin over WIDTH bits, LSB first, one bit per clock.
// A single full_subractor cell is reused every cycle with a registered borrow.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out
);

    localparam int unsigned   CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("serial_subtractor: WIDTH must be within 2..64");
        end
    endgenerate

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-2:0] r_res_sr;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] r_diff_out;
    logic             r_brw;
    logic             r_borrow_out;
    logic [CW-1:0]    r_cnt;
    logic             w_cell_diff;
    logic             w_cell_borrow;
    logic             w_last;

    full_subractor u_cell (
        .a      (r_a_sr[0]),
        .b      (r_b_sr[0]),
        .c      (r_brw),
        .diff   (w_cell_diff),
        .borrow (w_cell_borrow)
    );

    // Only WIDTH-1 history bits are stored; the new diff bit completes the word.
    assign w_res_next = {w_cell_diff, r_res_sr};
    assign w_last     = (r_cnt == LAST_BIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        ready  = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr       <= '0;
            r_b_sr       <= '0;
            r_res_sr     <= '0;
            r_brw        <= 1'b0;
            r_cnt        <= '0;
            r_diff_out   <= '0;
            r_borrow_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sr <= a_in;
                        r_b_sr <= b_in;
                        r_brw  <= bin_in;
                        r_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_res_sr <= w_res_next[WIDTH-1:1];
                    r_brw    <= w_cell_borrow;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_diff_out   <= w_res_next;
                        r_borrow_out <= w_cell_borrow;
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff_out   = r_diff_out;
    assign borrow_out = r_borrow_out;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 directed/random ops and WIDTH=4 exhaustive sweep,
// checked every cycle against a timing/arithmetic model.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       bin8 = 1'b0;
    logic       ready8, busy8, done8, bo8;
    logic [7:0] d8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       bin4 = 1'b0;
    logic       ready4, busy4, done4, bo4;
    logic [3:0] d4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .bin_in(bin8),
        .ready(ready8), .busy(busy8), .done(done8), .diff_out(d8), .borrow_out(bo8)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4), .bin_in(bin4),
        .ready(ready4), .busy(busy4), .done(done4), .diff_out(d4), .borrow_out(bo4)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 = idle, k = k edges since the accepting edge; done when k == W+1.
    int unsigned m_phase [2];
    logic [63:0] m_pend  [2];
    logic [63:0] m_diff  [2];
    logic        m_pbrw  [2];
    logic        m_brw   [2];

    task automatic model_step(input int i, input int unsigned w, input logic st,
                              input logic [63:0] a, input logic [63:0] b, input logic bi);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        if (m_phase[i] == 0) begin
            if (st) begin
                m_phase[i] = 1;
                m_pend[i]  = (a - b - {63'd0, bi}) & mask;
                m_pbrw[i]  = (a < (b + {63'd0, bi}));
            end
        end else if (m_phase[i] == w + 1) begin
            m_phase[i] = 0;
        end else begin
            m_phase[i] = m_phase[i] + 1;
            if (m_phase[i] == w + 1) begin
                m_diff[i] = m_pend[i];
                m_brw[i]  = m_pbrw[i];
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i] = 0;
                m_diff[i]  = '0;
                m_brw[i]   = 1'b0;
                m_pend[i]  = '0;
                m_pbrw[i]  = 1'b0;
            end
        end else begin
            model_step(0, 8, start8, {56'd0, a8}, {56'd0, b8}, bin8);
            model_step(1, 4, start4, {60'd0, a4}, {60'd0, b4}, bin4);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("w8_ready",  {63'd0, ready8}, {63'd0, m_phase[0] == 0});
            chk("w8_busy",   {63'd0, busy8},  {63'd0, m_phase[0] != 0});
            chk("w8_done",   {63'd0, done8},  {63'd0, m_phase[0] == 9});
            chk("w8_diff",   {56'd0, d8},     m_diff[0]);
            chk("w8_borrow", {63'd0, bo8},    {63'd0, m_brw[0]});
            chk("w4_ready",  {63'd0, ready4}, {63'd0, m_phase[1] == 0});
            chk("w4_busy",   {63'd0, busy4},  {63'd0, m_phase[1] != 0});
            chk("w4_done",   {63'd0, done4},  {63'd0, m_phase[1] == 5});
            chk("w4_diff",   {60'd0, d4},     m_diff[1]);
            chk("w4_borrow", {63'd0, bo4},    {63'd0, m_brw[1]});
        end
    end

    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic bi);
        a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    endtask

    task automatic wait_done8(output int cyc);
        cyc = 0;
        while (done8 !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("w8_done_seen", {63'd0, done8}, 64'd1);
    endtask

    task automatic wait_ready8();
        int g;
        g = 0;
        while (ready8 !== 1'b1 && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("w8_ready_seen", {63'd0, ready8}, 64'd1);
    endtask

    task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input logic [7:0] ed, input logic eb);
        int cyc;
        wait_ready8();
        launch8(a, b, bi);
        wait_done8(cyc);
        chk({nm, "_latency"}, cyc, 64'd8);
        chk({nm, "_diff"}, {56'd0, d8}, {56'd0, ed});
        chk({nm, "_borrow"}, {63'd0, bo8}, {63'd0, eb});
        @(negedge clk);
        chk({nm, "_ready_after"}, {63'd0, ready8}, 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        int g;
        int cyc;
        #1 rst = 1'b1;
        #2;
        chk("rst_diff8",   {56'd0, d8},     64'd0);
        chk("rst_borrow8", {63'd0, bo8},    64'd0);
        chk("rst_done8",   {63'd0, done8},  64'd0);
        chk("rst_busy8",   {63'd0, busy8},  64'd0);
        chk("rst_ready8",  {63'd0, ready8}, 64'd1);
        chk("rst_ready4",  {63'd0, ready4}, 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        op8("basic",     8'd100, 8'd37,  1'b0, 8'd63,  1'b0);
        op8("underflow", 8'h00,  8'h01,  1'b0, 8'hFF,  1'b1);
        op8("bin_eq",    8'h55,  8'h55,  1'b1, 8'hFF,  1'b1);
        op8("bin_max",   8'h00,  8'hFF,  1'b1, 8'h00,  1'b1);
        op8("equal",     8'hA7,  8'hA7,  1'b0, 8'h00,  1'b0);

        // start held through SHIFT with changing operands
        a8 = 8'd10; b8 = 8'd3; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            chk("busy_hold_diff", {56'd0, d8}, 64'd0);
            if (done8) n_done++;
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            @(negedge clk);
        end
        start8 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done8) begin
                n_done++;
                chk("busy_res_diff", {56'd0, d8}, 64'd7);
                chk("busy_res_borrow", {63'd0, bo8}, 64'd0);
            end
            @(negedge clk);
        end
        chk("busy_single_done", n_done, 64'd1);

        wait_ready8();
        launch8(8'd9, 8'd1, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_diff",  {56'd0, d8},     64'd0);
        chk("midrst_busy",  {63'd0, busy8},  64'd0);
        chk("midrst_ready", {63'd0, ready8}, 64'd1);
        chk("midrst_done",  {63'd0, done8},  64'd0);
        #1 rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done8) n_done++;
        end
        chk("midrst_no_done", n_done, 64'd0);
        op8("after_rst", 8'd200, 8'd55, 1'b0, 8'd145, 1'b0);

        for (int k = 0; k < 60; k++) begin
            g = 0;
            while (ready8 !== 1'b1 && g < 40) begin
                start8 = 1'($urandom);
                a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
                @(negedge clk);
                g++;
            end
            start8 = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            launch8(8'($urandom), 8'($urandom), 1'($urandom));
        end
        wait_done8(cyc);
        @(negedge clk);

        for (int unsigned ai = 0; ai < 16; ai++) begin
            for (int unsigned bi = 0; bi < 16; bi++) begin
                for (int unsigned ci = 0; ci < 2; ci++) begin
                    g = 0;
                    while (ready4 !== 1'b1 && g < 20) begin
                        @(negedge clk);
                        g++;
                    end
                    a4 = 4'(ai); b4 = 4'(bi); bin4 = 1'(ci); start4 = 1'b1;
                    @(negedge clk);
                    start4 = 1'b0;
                    g = 0;
                    while (done4 !== 1'b1 && g < 20) begin
                        @(negedge clk);
                        g++;
                    end
                    chk("exh_done_seen", {63'd0, done4}, 64'd1);
                    chk("exh_diff", {60'd0, d4}, 64'((ai - bi - ci) & 32'hF));
                    chk("exh_borrow", {63'd0, bo4}, {63'd0, ai < bi + ci});
                end
            end
        end
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
